avalon_arbiter: RTL and testbench

AVALON_ARBITER -- requirements
Module: avalon_arbiter

---
 rtl/avalon_arbiter.sv | 129 ++++++++++++
 tb/tb_avalon_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_arbiter.sv
// Two-master arbiter in front of a single Avalon-style slave: round-robin on ties,
// one transaction per grant, and a watchdog that force-completes a stalled transfer.
module avalon_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        M0_Read,
  input  logic        M0_Write,
  input  logic [15:0] M0_Addr,
  input  logic [15:0] M0_WrData,
  output logic [15:0] M0_RdData,
  output logic        M0_Waitreq,
  input  logic        M1_Read,
  input  logic        M1_Write,
  input  logic [15:0] M1_Addr,
  input  logic [15:0] M1_WrData,
  output logic [15:0] M1_RdData,
  output logic        M1_Waitreq,
  output logic        S_Read,
  output logic        S_Write,
  output logic [15:0] S_Addr,
  output logic [15:0] S_WrData,
  input  logic [15:0] S_RdData,
  input  logic        S_Waitreq,
  output logic [1:0]  Gnt,
  output logic        Timeout
);

  // State codes double as the one-hot grant vector.
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] BUSY0 = 2'b01;
  localparam logic [1:0] BUSY1 = 2'b10;

  // The watchdog fires on the stalled cycle that would bring the count up to TIMEOUT.
  localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);
  localparam logic [15:0] ForcedRdData = 16'hDEAD;

  logic [1:0]  state;
  logic [1:0]  nextState;
  logic        lastGnt;
  logic [7:0]  wdCnt;
  logic        timeoutQ;

  logic        req0;
  logic        req1;
  logic        ownRead;
  logic        ownWrite;
  logic        ownReq;
  logic [15:0] ownAddr;
  logic [15:0] ownWrData;
  logic        forceDone;

  assign req0 = M0_Read | M0_Write;
  assign req1 = M1_Read | M1_Write;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ownRead   = 1'b0;
    ownWrite  = 1'b0;
    ownAddr   = '0;
    ownWrData = '0;
    case (state)
      BUSY0: begin
        ownRead   = M0_Read;
        ownWrite  = M0_Write;
        ownAddr   = M0_Addr;
        ownWrData = M0_WrData;
      end
      BUSY1: begin
        ownRead   = M1_Read;
        ownWrite  = M1_Write;
        ownAddr   = M1_Addr;
        ownWrData = M1_WrData;
      end
      default: ;
    endcase
  end

  assign ownReq    = ownRead | ownWrite;
  assign forceDone = (state != IDLE) & ownReq & S_Waitreq & (wdCnt == LastCnt);

  // Write wins over read; a forced completion pulls both slave strobes.
  assign S_Read   = ownRead & ~ownWrite & ~forceDone;
  assign S_Write  = ownWrite & ~forceDone;
  assign S_Addr   = ownAddr;
  assign S_WrData = ownWrData;

  assign M0_Waitreq = (state == BUSY0) ? (S_Waitreq & ~forceDone) : 1'b1;
  assign M1_Waitreq = (state == BUSY1) ? (S_Waitreq & ~forceDone) : 1'b1;
  assign M0_RdData  = (state == BUSY0 && forceDone) ? ForcedRdData : S_RdData;
  assign M1_RdData  = (state == BUSY1 && forceDone) ? ForcedRdData : S_RdData;

  assign Gnt     = state;
  assign Timeout = timeoutQ;

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (req0 && req1)  nextState = lastGnt ? BUSY0 : BUSY1;
        else if (req0)     nextState = BUSY0;
        else if (req1)     nextState = BUSY1;
      end
      BUSY0, BUSY1: begin
        // Completion, abort and forced completion all return to IDLE.
        if (!ownReq || !S_Waitreq || forceDone) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      lastGnt  <= 1'b1;
      wdCnt    <= '0;
      timeoutQ <= 1'b0;
    end else begin
      state <= nextState;
      if (state == IDLE && nextState != IDLE) lastGnt <= nextState[1];
      if (state == IDLE || nextState == IDLE) wdCnt <= '0;
      else if (S_Waitreq)                     wdCnt <= wdCnt + 8'd1;
      if (forceDone) timeoutQ <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avalon_arbiter.sv
// Bench for avalon_arbiter: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a transaction-level model of the arbiter.
module tb_avalon_arbiter;

  localparam int TMO = 4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        mRead   [2];
  logic        mWrite  [2];
  logic [15:0] mAddr   [2];
  logic [15:0] mWrData [2];
  logic [15:0] M0_RdData, M1_RdData;
  logic        M0_Waitreq, M1_Waitreq;
  logic        S_Read, S_Write;
  logic [15:0] S_Addr, S_WrData;
  logic [15:0] S_RdData;
  logic        S_Waitreq;
  logic [1:0]  Gnt;
  logic        Timeout;

  // Model: who owns the bus (-1 = nobody), who was served last, stalls so far.
  int owner;
  int lastServed;
  int stallCnt;
  bit tmoFlag;
  bit pend [2];

  int assertCount = 0;
  int failCount   = 0;

  always #5 Clock = ~Clock;

  avalon_arbiter #(.TIMEOUT(TMO)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .M0_Read    (mRead[0]),
    .M0_Write   (mWrite[0]),
    .M0_Addr    (mAddr[0]),
    .M0_WrData  (mWrData[0]),
    .M0_RdData  (M0_RdData),
    .M0_Waitreq (M0_Waitreq),
    .M1_Read    (mRead[1]),
    .M1_Write   (mWrite[1]),
    .M1_Addr    (mAddr[1]),
    .M1_WrData  (mWrData[1]),
    .M1_RdData  (M1_RdData),
    .M1_Waitreq (M1_Waitreq),
    .S_Read     (S_Read),
    .S_Write    (S_Write),
    .S_Addr     (S_Addr),
    .S_WrData   (S_WrData),
    .S_RdData   (S_RdData),
    .S_Waitreq  (S_Waitreq),
    .Gnt        (Gnt),
    .Timeout    (Timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clearInputs();
    for (int m = 0; m < 2; m++) begin
      mRead[m]   = 1'b0;
      mWrite[m]  = 1'b0;
      mAddr[m]   = '0;
      mWrData[m] = '0;
    end
    S_Waitreq = 1'b0;
    S_RdData  = '0;
  endtask

  // Expected outputs of the current cycle, from model state and present inputs.
  task automatic checkOutputs(input string ctx);
    logic [1:0]  eGnt;
    logic        eRead, eWrite;
    logic [15:0] eAddr, eWrData;
    logic        eWait [2];
    logic [15:0] eRd   [2];
    bit          forced;
    eGnt = 2'b00; eRead = 1'b0; eWrite = 1'b0; eAddr = '0; eWrData = '0;
    forced = 1'b0;
    for (int m = 0; m < 2; m++) begin
      eWait[m] = 1'b1;
      eRd[m]   = S_RdData;
    end
    if (owner >= 0) begin
      eGnt    = (owner == 0) ? 2'b01 : 2'b10;
      forced  = (mRead[owner] || mWrite[owner]) && S_Waitreq && (stallCnt + 1 == TMO);
      eRead   = mRead[owner] && !mWrite[owner] && !forced;
      eWrite  = mWrite[owner] && !forced;
      eAddr   = mAddr[owner];
      eWrData = mWrData[owner];
      eWait[owner] = forced ? 1'b0 : S_Waitreq;
      if (forced) eRd[owner] = 16'hDEAD;
    end
    check({ctx, ".Gnt"},        Gnt,        eGnt);
    check({ctx, ".S_Read"},     S_Read,     eRead);
    check({ctx, ".S_Write"},    S_Write,    eWrite);
    check({ctx, ".S_Addr"},     S_Addr,     eAddr);
    check({ctx, ".S_WrData"},   S_WrData,   eWrData);
    check({ctx, ".M0_Waitreq"}, M0_Waitreq, eWait[0]);
    check({ctx, ".M1_Waitreq"}, M1_Waitreq, eWait[1]);
    check({ctx, ".M0_RdData"},  M0_RdData,  eRd[0]);
    check({ctx, ".M1_RdData"},  M1_RdData,  eRd[1]);
    check({ctx, ".Timeout"},    Timeout,    tmoFlag);
  endtask

  task automatic sample(input string ctx);
    @(negedge Clock);
    checkOutputs(ctx);
  endtask

  // Apply this cycle's inputs to the model, then move to the next cycle.
  task automatic advance();
    bit r0, r1, req;
    if (Reset) begin
      owner = -1; lastServed = 1; stallCnt = 0; tmoFlag = 1'b0;
    end else if (owner < 0) begin
      r0 = mRead[0] || mWrite[0];
      r1 = mRead[1] || mWrite[1];
      if (r0 && r1)  owner = 1 - lastServed;
      else if (r0)   owner = 0;
      else if (r1)   owner = 1;
      if (owner >= 0) lastServed = owner;
      stallCnt = 0;
    end else begin
      req = mRead[owner] || mWrite[owner];
      if (!req) begin
        owner = -1;
      end else if (!S_Waitreq) begin
        pend[owner] = 1'b0;
        owner = -1;
      end else if (stallCnt + 1 == TMO) begin
        tmoFlag = 1'b1;
        pend[owner] = 1'b0;
        owner = -1;
      end else begin
        stallCnt++;
      end
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic step(input string ctx);
    sample(ctx);
    advance();
  endtask

  task automatic doReset();
    Reset = 1'b1;
    step("rst");
    Reset = 1'b0;
  endtask

  initial begin
    logic [1:0] seq38 [5];
    logic [1:0] seq39 [8];
    int bias;
    seq38 = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    seq39 = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    clearInputs();
    pend[0] = 1'b0; pend[1] = 1'b0;
    owner = -1; lastServed = 1; stallCnt = 0; tmoFlag = 1'b0;
    Reset = 1'b1;
    @(posedge Clock);
    #1;

    // Reset state
    sample("reset");
    check("reset.Gnt", Gnt, 2'b00);
    check("reset.M0_Waitreq", M0_Waitreq, 1'b1);
    check("reset.M1_Waitreq", M1_Waitreq, 1'b1);
    check("reset.Timeout", Timeout, 1'b0);
    check("reset.S_Write", S_Write, 1'b0);
    advance();
    Reset = 1'b0;

    // Single zero-wait read from M0
    mRead[0] = 1'b1; mAddr[0] = 16'h0010; S_RdData = 16'h1234;
    sample("rd0.idle");
    check("rd0.idle.Gnt", Gnt, 2'b00);
    advance();
    sample("rd0.busy");
    check("rd0.busy.Gnt", Gnt, 2'b01);
    check("rd0.busy.M0_Waitreq", M0_Waitreq, 1'b0);
    check("rd0.busy.M0_RdData", M0_RdData, 16'h1234);
    check("rd0.busy.S_Addr", S_Addr, 16'h0010);
    advance();
    mRead[0] = 1'b0;
    sample("rd0.after");
    check("rd0.after.Gnt", Gnt, 2'b00);
    advance();

    // Simultaneous writes from reset: M0 first, then M1
    doReset();
    mWrite[0] = 1'b1; mWrData[0] = 16'hAAAA; mAddr[0] = 16'h0100;
    mWrite[1] = 1'b1; mWrData[1] = 16'h5555; mAddr[1] = 16'h0200;
    for (int i = 0; i < 5; i++) begin
      sample("wr2");
      check("wr2.GntSeq", Gnt, seq38[i]);
      if (seq38[i] == 2'b01) check("wr2.S_WrData0", S_WrData, 16'hAAAA);
      if (seq38[i] == 2'b10) check("wr2.S_WrData1", S_WrData, 16'h5555);
      advance();
      if (i == 1) mWrite[0] = 1'b0;
      if (i == 3) mWrite[1] = 1'b0;
    end

    // Both masters requesting continuously: grants alternate
    doReset();
    mRead[0] = 1'b1; mRead[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample("alt");
      check("alt.GntSeq", Gnt, seq39[i]);
      advance();
    end
    clearInputs();

    // Read and write together: write wins
    doReset();
    mRead[0] = 1'b1; mWrite[0] = 1'b1; mWrData[0] = 16'hC0DE;
    step("rw.idle");
    sample("rw.busy");
    check("rw.S_Write", S_Write, 1'b1);
    check("rw.S_Read", S_Read, 1'b0);
    advance();
    clearInputs();

    // Watchdog: fourth stalled cycle is force-completed
    doReset();
    mRead[0] = 1'b1; S_Waitreq = 1'b1; S_RdData = 16'h4321;
    step("wd.idle");
    for (int i = 1; i <= 4; i++) begin
      sample("wd.stall");
      if (i < 4) begin
        check("wd.stall.M0_Waitreq", M0_Waitreq, 1'b1);
      end else begin
        check("wd.force.M0_Waitreq", M0_Waitreq, 1'b0);
        check("wd.force.M0_RdData", M0_RdData, 16'hDEAD);
        check("wd.force.M1_RdData", M1_RdData, 16'h4321);
        check("wd.force.S_Read", S_Read, 1'b0);
      end
      advance();
    end
    mRead[0] = 1'b0; S_Waitreq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample("wd.sticky");
      check("wd.sticky.Timeout", Timeout, 1'b1);
      check("wd.sticky.Gnt", Gnt, 2'b00);
      advance();
    end

    // Reset during a stalled BUSY1 abandons it and clears Timeout
    mWrite[1] = 1'b1; mWrData[1] = 16'hBEEF; S_Waitreq = 1'b1;
    step("rstBusy.idle");
    sample("rstBusy.busy");
    check("rstBusy.busy.Gnt", Gnt, 2'b10);
    Reset = 1'b1;
    advance();
    Reset = 1'b0;
    mWrite[1] = 1'b1;
    sample("rstBusy.after");
    check("rstBusy.after.Gnt", Gnt, 2'b00);
    check("rstBusy.after.S_Write", S_Write, 1'b0);
    check("rstBusy.after.M1_Waitreq", M1_Waitreq, 1'b1);
    check("rstBusy.after.Timeout", Timeout, 1'b0);
    advance();
    clearInputs();
    step("idle");

    // Randomized traffic against the model
    bias = 0;
    for (int c = 0; c < 3000; c++) begin
      Reset = ($urandom_range(0, 299) == 0);
      for (int m = 0; m < 2; m++) begin
        if (!pend[m]) begin
          mRead[m] = 1'b0; mWrite[m] = 1'b0;
          if ($urandom_range(0, 2) == 0) begin
            int kind;
            kind = $urandom_range(0, 5);
            mRead[m]   = (kind <= 2) || (kind == 5);
            mWrite[m]  = (kind >= 3);
            mAddr[m]   = 16'($urandom);
            mWrData[m] = 16'($urandom);
            pend[m]    = 1'b1;
          end
        end else if ($urandom_range(0, 39) == 0) begin
          mRead[m] = 1'b0; mWrite[m] = 1'b0; pend[m] = 1'b0;
        end
      end
      if (c % 32 == 0) bias = $urandom_range(0, 3);
      S_Waitreq = ($urandom_range(0, 99) < bias * 30);
      S_RdData  = 16'($urandom);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
